dp_enable_scheduler: RTL and testbench

//  Sequences the PE grid of the matrix-multiply datapath: on start, raises the per-PE enables in staggered groups.

---
 rtl/dp_enable_scheduler.sv | 129 ++++++++++++
 tb/tb_dp_enable_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dp_enable_scheduler.sv
// Staggered enable sequencer for the matrix-multiply PE grid: turns on PE groups a few
// at a time, then waits for the output writer and reports done, timeout or abort.
module dp_enable_scheduler #(
    parameter int ROW1    = 2,
    parameter int COL2    = 5,
    parameter int ROW2    = 3,
    parameter int GROUP   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [7:0]                  stagger,
    input  logic                        dp_done,
    output logic [ROW1*COL2*ROW2-1:0]   en_flat,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err
);

    localparam int N  = ROW1 * COL2 * ROW2;
    localparam int PW = $clog2(N + 1);
    localparam int WW = $clog2(TIMEOUT);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] GAP       = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] FINISH    = 3'd4;

    logic [2:0]    state;
    logic [PW-1:0] ptr;
    logic [7:0]    gap_cnt;
    logic [WW-1:0] wd_cnt;

    logic [PW:0]   ptr_ext;
    logic [PW:0]   ptr_sum;
    logic [PW-1:0] ptr_next;
    logic [N-1:0]  issue_mask;

    // One extra bit keeps ptr+GROUP from wrapping before it is clipped to N.
    always_comb begin
        ptr_ext    = {1'b0, ptr};
        ptr_sum    = ptr_ext + (PW+1)'(GROUP);
        ptr_next   = (ptr_sum >= (PW+1)'(N)) ? PW'(N) : ptr_sum[PW-1:0];
        issue_mask = '0;
        for (int b = 0; b < N; b++) begin
            issue_mask[b] = ((PW+1)'(b) >= ptr_ext) && ((PW+1)'(b) < ptr_sum);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            gap_cnt     <= '0;
            wd_cnt      <= '0;
            en_flat     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done <= 1'b0;
            // Abort beats everything, including a same-cycle dp_done.
            if (state != IDLE && abort) begin
                state   <= IDLE;
                en_flat <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state       <= ISSUE;
                            ptr         <= '0;
                            en_flat     <= '0;
                            timeout_err <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        en_flat <= en_flat | issue_mask;
                        ptr     <= ptr_next;
                        if (ptr_next == PW'(N)) begin
                            state  <= WAIT_DONE;
                            wd_cnt <= '0;
                        end else if (stagger == 8'd0) begin
                            state <= ISSUE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= stagger;
                        end
                    end
                    GAP: begin
                        gap_cnt <= gap_cnt - 8'd1;
                        if (gap_cnt == 8'd1) begin
                            state <= ISSUE;
                        end
                    end
                    WAIT_DONE: begin
                        if (dp_done) begin
                            state   <= FINISH;
                            en_flat <= '0;
                            done    <= 1'b1;
                        end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
                            state       <= IDLE;
                            en_flat     <= '0;
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                        end else if (wd_cnt != '1) begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                    FINISH: begin
                        state   <= IDLE;
                        en_flat <= '0;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        en_flat <= '0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dp_enable_scheduler.sv
// Scoreboard bench for dp_enable_scheduler: expected output snapshots are queued per
// cycle when a job is launched and compared on the falling edge as the DUT advances.
module tb_dp_enable_scheduler;

    localparam int NPE = 30;

    logic            clk;
    logic            rst;
    logic            start;
    logic            abort;
    logic [7:0]      stagger;
    logic            dpDone;
    logic [NPE-1:0]  enFlat;
    logic            busy;
    logic            done;
    logic            timeoutErr;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    typedef struct {
        int             cyc;
        logic [NPE-1:0] en;
        logic           busy;
        logic           done;
        logic           terr;
        string          tag;
    } expRec_t;

    expRec_t sb[$];

    dp_enable_scheduler #(
        .ROW1(2), .COL2(5), .ROW2(3), .GROUP(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .stagger(stagger),
        .dp_done(dpDone), .en_flat(enFlat), .busy(busy), .done(done),
        .timeout_err(timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NPE-1:0] stepMask(input int k);
        logic [NPE-1:0] m;
        m = '0;
        for (int b = 0; b < NPE; b++) m[b] = (b < 4 * k);
        return m;
    endfunction

    task automatic pushExpect(input int c, input logic [NPE-1:0] en, input logic b,
                              input logic d, input logic te, input string tag, input int off);
        expRec_t r;
        r.cyc  = c;
        r.en   = en;
        r.busy = b;
        r.done = d;
        r.terr = te;
        r.tag  = $sformatf("%s+%0d", tag, off);
        sb.push_back(r);
    endtask

    always @(negedge clk) begin
        expRec_t r;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            r = sb.pop_front();
            checkOutput({r.tag, "_en"},   32'(enFlat),     32'(r.en));
            checkOutput({r.tag, "_busy"}, 32'(busy),       32'(r.busy));
            checkOutput({r.tag, "_done"}, 32'(done),       32'(r.done));
            checkOutput({r.tag, "_terr"}, 32'(timeoutErr), 32'(r.terr));
        end
    end

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called on a falling edge: raises start so it is sampled on the next rising edge.
    task automatic applyStimulus(input logic [7:0] stag, output int t);
        stagger = stag;
        start   = 1'b1;
        t       = cyc + 1;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) checkOutput("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic runFastJob(input string tag);
        int t;
        applyStimulus(8'd0, t);
        pushExpect(t, '0, 1, 0, 0, tag, 0);
        for (int m = 1; m <= 20; m++) pushExpect(t + m, stepMask(m), 1, 0, 0, tag, m);
        pushExpect(t + 21, '0, 1, 1, 0, tag, 21);
        pushExpect(t + 22, '0, 0, 0, 0, tag, 22);
        waitUntil(t);
        start = 1'b0;
        waitUntil(t + 20);
        dpDone = 1'b1;
        @(negedge clk);
        dpDone = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got %0d tests run", testsRun);
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int t;
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        stagger = 8'd0;
        dpDone  = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_en",   32'(enFlat),     32'd0);
        checkOutput("reset_busy", 32'(busy),       32'd0);
        checkOutput("reset_done", 32'(done),       32'd0);
        checkOutput("reset_terr", 32'(timeoutErr), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // T1: back-to-back issue, completion on dp_done
        runFastJob("t1");

        // T2: stagger=3, groups every 4 cycles
        applyStimulus(8'd3, t);
        pushExpect(t, '0, 1, 0, 0, "t2", 0);
        for (int c = 1; c <= 30; c++) pushExpect(t + c, stepMask((c - 1) / 4 + 1), 1, 0, 0, "t2", c);
        pushExpect(t + 31, '0, 1, 1, 0, "t2", 31);
        pushExpect(t + 32, '0, 0, 0, 0, "t2", 32);
        waitUntil(t);
        start = 1'b0;
        waitUntil(t + 30);
        dpDone = 1'b1;
        @(negedge clk);
        dpDone = 1'b0;
        drain();

        // T3: watchdog expiry with no dp_done
        applyStimulus(8'd0, t);
        for (int m = 0; m <= 23; m++) pushExpect(t + m, stepMask(m), 1, 0, 0, "t3", m);
        pushExpect(t + 24, '0, 0, 0, 1, "t3", 24);
        pushExpect(t + 25, '0, 0, 0, 1, "t3", 25);
        pushExpect(t + 26, '0, 0, 0, 1, "t3", 26);
        waitUntil(t);
        start = 1'b0;
        drain();

        // T4: abort in GAP after step 3 with dp_done high; start also clears timeout_err
        applyStimulus(8'd3, t);
        pushExpect(t, '0, 1, 0, 0, "t4", 0);
        for (int c = 1; c <= 9; c++) pushExpect(t + c, stepMask((c - 1) / 4 + 1), 1, 0, 0, "t4", c);
        for (int c = 10; c <= 13; c++) pushExpect(t + c, '0, 0, 0, 0, "t4", c);
        waitUntil(t);
        start = 1'b0;
        waitUntil(t + 9);
        abort  = 1'b1;
        dpDone = 1'b1;
        @(negedge clk);
        abort  = 1'b0;
        dpDone = 1'b0;
        drain();

        // T6: stray dp_done in ISSUE and start while busy are both ignored
        applyStimulus(8'd0, t);
        for (int m = 0; m <= 12; m++) pushExpect(t + m, stepMask(m), 1, 0, 0, "t6", m);
        pushExpect(t + 13, '0, 1, 1, 0, "t6", 13);
        pushExpect(t + 14, '0, 0, 0, 0, "t6", 14);
        pushExpect(t + 15, '0, 0, 0, 0, "t6", 15);
        waitUntil(t);
        start = 1'b0;
        waitUntil(t + 2);
        dpDone = 1'b1;
        @(negedge clk);
        dpDone = 1'b0;
        waitUntil(t + 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitUntil(t + 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitUntil(t + 12);
        dpDone = 1'b1;
        @(negedge clk);
        dpDone = 1'b0;
        drain();

        // T5: asynchronous reset in WAIT_DONE, then a clean job
        applyStimulus(8'd0, t);
        for (int m = 0; m <= 12; m++) pushExpect(t + m, stepMask(m), 1, 0, 0, "t5", m);
        waitUntil(t);
        start = 1'b0;
        waitUntil(t + 12);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("t5_async_en",   32'(enFlat),     32'd0);
        checkOutput("t5_async_busy", 32'(busy),       32'd0);
        checkOutput("t5_async_done", 32'(done),       32'd0);
        checkOutput("t5_async_terr", 32'(timeoutErr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        runFastJob("t5_after");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
